// File: rtl/issue_queue.sv
// Collapsing, age-ordered issue queue: takes up to 2 renamed instructions per cycle, wakes sources from wb tags, issues oldest ready.
// Latency: insert -> issue_valid min 2 cycles (1 if ready at insert is captured, then 1 for select); wakeup -> eligible 1 cycle.
// Backpressure: full stalls rename when <2 free slots; output register holds while issue_valid && ~issue_ready.
module issue_queue #(
    parameter int DEPTH     = 8,
    parameter int PR_W      = 6,
    parameter int AL_W      = 5,
    parameter int CP_W      = 2,
    parameter int PAYLOAD_W = 64,
    parameter int NUM_WB    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [1:0]               in_valid,
    input  logic [1:0]               in_uses_rs1,
    input  logic [1:0]               in_uses_rs2,
    input  logic [2*PR_W-1:0]        in_rs1,
    input  logic [2*PR_W-1:0]        in_rs2,
    input  logic [1:0]               in_rs1_ready,
    input  logic [1:0]               in_rs2_ready,
    input  logic [2*PR_W-1:0]        in_rd,
    input  logic [2*AL_W-1:0]        in_al_addr,
    input  logic [2*CP_W-1:0]        in_cp_addr,
    input  logic [2*PAYLOAD_W-1:0]   in_payload,
    output logic                     full,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*PR_W-1:0]   wb_tag,
    output logic                     issue_valid,
    input  logic                     issue_ready,
    output logic [PR_W-1:0]          issue_rs1,
    output logic [PR_W-1:0]          issue_rs2,
    output logic [PR_W-1:0]          issue_rd,
    output logic [AL_W-1:0]          issue_al_addr,
    output logic [CP_W-1:0]          issue_cp_addr,
    output logic [PAYLOAD_W-1:0]     issue_payload,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Fields that travel unchanged to the execute stage.
    typedef struct packed {
        logic [PR_W-1:0]      rs1;
        logic [PR_W-1:0]      rs2;
        logic [PR_W-1:0]      rd;
        logic [AL_W-1:0]      al_addr;
        logic [CP_W-1:0]      cp_addr;
        logic [PAYLOAD_W-1:0] payload;
    } iss_t;

    // One queue slot: source tracking plus the issue data.
    typedef struct packed {
        logic uses_rs1;
        logic rs1_rdy;
        logic uses_rs2;
        logic rs2_rdy;
        iss_t dat;
    } ent_t;

    ent_t             ent_q [DEPTH];
    ent_t             ent_d [DEPTH];
    ent_t             new_ent [2];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] cnt_rm;
    logic [CNT_W-1:0] pos0;
    logic [CNT_W-1:0] pos1;
    logic [DEPTH-1:0] ent_rdy;
    logic             sel_found;
    logic [CNT_W-1:0] sel_idx;
    iss_t             sel_dat;
    iss_t             iss_q;
    logic             out_free;
    logic             load;
    logic             acc0;
    logic             acc1;

    // Pure equality against every valid broadcast port; tag 0 is an ordinary tag.
    function automatic logic wb_hit(input logic [PR_W-1:0] tag);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid[k] && (wb_tag[k*PR_W +: PR_W] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    assign count    = count_q;
    assign full     = (count_q > CNT_W'(DEPTH - 2));
    assign out_free = ~issue_valid | issue_ready;
    assign load     = sel_found & out_free;
    assign acc0     = ~full & in_valid[0];
    assign acc1     = ~full & in_valid[1];

    assign issue_rs1     = iss_q.rs1;
    assign issue_rs2     = iss_q.rs2;
    assign issue_rd      = iss_q.rd;
    assign issue_al_addr = iss_q.al_addr;
    assign issue_cp_addr = iss_q.cp_addr;
    assign issue_payload = iss_q.payload;

    // Unpack the two rename slots into entry form.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            new_ent[s].uses_rs1    = in_uses_rs1[s];
            new_ent[s].rs1_rdy     = in_rs1_ready[s];
            new_ent[s].uses_rs2    = in_uses_rs2[s];
            new_ent[s].rs2_rdy     = in_rs2_ready[s];
            new_ent[s].dat.rs1     = in_rs1[s*PR_W +: PR_W];
            new_ent[s].dat.rs2     = in_rs2[s*PR_W +: PR_W];
            new_ent[s].dat.rd      = in_rd[s*PR_W +: PR_W];
            new_ent[s].dat.al_addr = in_al_addr[s*AL_W +: AL_W];
            new_ent[s].dat.cp_addr = in_cp_addr[s*CP_W +: CP_W];
            new_ent[s].dat.payload = in_payload[s*PAYLOAD_W +: PAYLOAD_W];
        end
    end

    // Issue eligibility from registered ready bits; valid entries are exactly indices below count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_rdy[i] = (CNT_W'(i) < count_q)
                       && (~ent_q[i].uses_rs1 || ent_q[i].rs1_rdy)
                       && (~ent_q[i].uses_rs2 || ent_q[i].rs2_rdy);
        end
    end

    // Oldest-first select: scan downward so the lowest ready index wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_dat   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_rdy[i]) begin
                sel_found = 1'b1;
                sel_idx   = CNT_W'(i);
                sel_dat   = ent_q[i].dat;
            end
        end
    end

    // Next queue image: remove selected, collapse, append slot 0 then slot 1, then wake (covers the insert bypass).
    always_comb begin
        cnt_rm  = count_q - CNT_W'(load);
        pos0    = cnt_rm;
        pos1    = cnt_rm + CNT_W'(acc0);
        count_d = cnt_rm + CNT_W'(acc0) + CNT_W'(acc1);
        for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
        if (load) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (CNT_W'(i) >= sel_idx) ent_d[i] = ent_q[i+1];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (acc0 && (CNT_W'(i) == pos0)) ent_d[i] = new_ent[0];
            if (acc1 && (CNT_W'(i) == pos1)) ent_d[i] = new_ent[1];
            ent_d[i].rs1_rdy = ent_d[i].rs1_rdy | wb_hit(ent_d[i].dat.rs1);
            ent_d[i].rs2_rdy = ent_d[i].rs2_rdy | wb_hit(ent_d[i].dat.rs2);
        end
    end

    // Queue state; flush drops everything including same-cycle inputs and wakeups.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
        end
    end

    // Output register: reloads whenever free, holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            issue_valid <= 1'b0;
            iss_q       <= '0;
        end else if (out_free) begin
            issue_valid <= sel_found;
            if (sel_found) iss_q <= sel_dat;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
module tb_issue_queue;
    localparam int DEPTH = 8, PR_W = 6, AL_W = 5, CP_W = 2, PAYLOAD_W = 64, NUM_WB = 4;

    logic                   clk = 1'b0;
    logic                   reset, flush;
    logic [1:0]             in_valid, in_uses_rs1, in_uses_rs2, in_rs1_ready, in_rs2_ready;
    logic [2*PR_W-1:0]      in_rs1, in_rs2, in_rd;
    logic [2*AL_W-1:0]      in_al_addr;
    logic [2*CP_W-1:0]      in_cp_addr;
    logic [2*PAYLOAD_W-1:0] in_payload;
    logic                   full;
    logic [NUM_WB-1:0]      wb_valid;
    logic [NUM_WB*PR_W-1:0] wb_tag;
    logic                   issue_valid, issue_ready;
    logic [PR_W-1:0]        issue_rs1, issue_rs2, issue_rd;
    logic [AL_W-1:0]        issue_al_addr;
    logic [CP_W-1:0]        issue_cp_addr;
    logic [PAYLOAD_W-1:0]   issue_payload;
    logic [$clog2(DEPTH):0] count;

    issue_queue #(.DEPTH(DEPTH), .PR_W(PR_W), .AL_W(AL_W), .CP_W(CP_W),
                  .PAYLOAD_W(PAYLOAD_W), .NUM_WB(NUM_WB)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_ready(in_rs1_ready), .in_rs2_ready(in_rs2_ready),
        .in_rd(in_rd), .in_al_addr(in_al_addr), .in_cp_addr(in_cp_addr), .in_payload(in_payload),
        .full(full), .wb_valid(wb_valid), .wb_tag(wb_tag),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
        .issue_al_addr(issue_al_addr), .issue_cp_addr(issue_cp_addr), .issue_payload(issue_payload),
        .count(count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: an age-ordered list of instructions plus the output register.
    typedef struct {
        logic                 u1, r1, u2, r2;
        logic [PR_W-1:0]      s1, s2, rd;
        logic [AL_W-1:0]      al;
        logic [CP_W-1:0]      cp;
        logic [PAYLOAD_W-1:0] pl;
    } m_ent_t;

    m_ent_t mq[$];
    logic   m_iv = 1'b0;
    m_ent_t m_iss;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_hit(input logic [PR_W-1:0] t);
        for (int k = 0; k < NUM_WB; k++)
            if (wb_valid[k] && wb_tag[k*PR_W +: PR_W] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_ready(input m_ent_t e);
        return (!e.u1 || e.r1) && (!e.u2 || e.r2);
    endfunction

    // Advance the model across one clock edge using the inputs currently driven.
    function automatic void model_step();
        int     sel;
        bit     full_m;
        m_ent_t e;
        if (reset || flush) begin
            mq.delete();
            m_iv = 1'b0;
            return;
        end
        full_m = mq.size() > DEPTH - 2;
        sel = -1;
        foreach (mq[i]) if (sel < 0 && m_ready(mq[i])) sel = i;
        if (!m_iv || issue_ready) begin
            if (sel >= 0) begin
                m_iss = mq[sel];
                m_iv  = 1'b1;
                mq.delete(sel);
            end else begin
                m_iv = 1'b0;
            end
        end
        if (!full_m) begin
            for (int s = 0; s < 2; s++) begin
                if (in_valid[s]) begin
                    e.u1 = in_uses_rs1[s];  e.r1 = in_rs1_ready[s];  e.s1 = in_rs1[s*PR_W +: PR_W];
                    e.u2 = in_uses_rs2[s];  e.r2 = in_rs2_ready[s];  e.s2 = in_rs2[s*PR_W +: PR_W];
                    e.rd = in_rd[s*PR_W +: PR_W];
                    e.al = in_al_addr[s*AL_W +: AL_W];
                    e.cp = in_cp_addr[s*CP_W +: CP_W];
                    e.pl = in_payload[s*PAYLOAD_W +: PAYLOAD_W];
                    mq.push_back(e);
                end
            end
        end
        foreach (mq[i]) begin
            if (m_hit(mq[i].s1)) mq[i].r1 = 1'b1;
            if (m_hit(mq[i].s2)) mq[i].r2 = 1'b1;
        end
    endfunction

    task automatic check_all();
        chk("count", 64'(count), 64'(mq.size()));
        chk("full", 64'(full), 64'(mq.size() > DEPTH - 2));
        chk("issue_valid", 64'(issue_valid), 64'(m_iv));
        if (m_iv) begin
            chk("issue_rs1", 64'(issue_rs1), 64'(m_iss.s1));
            chk("issue_rs2", 64'(issue_rs2), 64'(m_iss.s2));
            chk("issue_rd", 64'(issue_rd), 64'(m_iss.rd));
            chk("issue_al", 64'(issue_al_addr), 64'(m_iss.al));
            chk("issue_cp", 64'(issue_cp_addr), 64'(m_iss.cp));
            chk("issue_payload", issue_payload, m_iss.pl);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic clear_inputs();
        flush = 0; in_valid = 0; in_uses_rs1 = 0; in_uses_rs2 = 0;
        in_rs1_ready = 0; in_rs2_ready = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
        in_al_addr = 0; in_cp_addr = 0; in_payload = 0; wb_valid = 0; wb_tag = 0;
    endtask

    task automatic set_slot(input int s, input bit u1, input logic [PR_W-1:0] s1, input bit r1,
                            input bit u2, input logic [PR_W-1:0] s2, input bit r2,
                            input logic [AL_W-1:0] al);
        in_valid[s] = 1'b1;
        in_uses_rs1[s] = u1;  in_rs1[s*PR_W +: PR_W] = s1;  in_rs1_ready[s] = r1;
        in_uses_rs2[s] = u2;  in_rs2[s*PR_W +: PR_W] = s2;  in_rs2_ready[s] = r2;
        in_rd[s*PR_W +: PR_W] = PR_W'(al) + 6'd1;
        in_al_addr[s*AL_W +: AL_W] = al;
        in_cp_addr[s*CP_W +: CP_W] = al[CP_W-1:0];
        in_payload[s*PAYLOAD_W +: PAYLOAD_W] = {$urandom, $urandom};
    endtask

    task automatic wb0(input logic [PR_W-1:0] t);
        wb_valid = 4'b0001;
        wb_tag = '0;
        wb_tag[PR_W-1:0] = t;
    endtask

    typedef struct {
        logic [1:0]      iv;
        logic [1:0]      u1;
        logic [PR_W-1:0] t0;
        logic [AL_W-1:0] al0, al1;
        logic            wbv;
        logic [PR_W-1:0] wbt;
        int              e_cnt;
        logic            e_iv;
        logic [AL_W-1:0] e_al;
    } vec_t;

    vec_t tbl[15];

    initial begin
        // iv   u1     t0  al0 al1 wbv wbt  cnt iv al
        tbl[0]  = '{2'b11, 2'b00, 0, 0, 1, 0, 0, 2, 0, 0};  // two ready
        tbl[1]  = '{2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0};
        tbl[2]  = '{2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1};
        tbl[3]  = '{2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{2'b11, 2'b01, 7, 2, 3, 0, 0, 2, 0, 0};  // older A waits on 7
        tbl[5]  = '{2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1, 3};  // younger B first
        tbl[6]  = '{2'b00, 2'b00, 0, 0, 0, 1, 7, 1, 0, 0};  // broadcast 7
        tbl[7]  = '{2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2};
        tbl[8]  = '{2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{2'b01, 2'b01, 9, 4, 0, 1, 9, 1, 0, 0};  // insert bypass
        tbl[10] = '{2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 4};
        tbl[11] = '{2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[12] = '{2'b10, 2'b00, 0, 0, 5, 0, 0, 1, 0, 0};  // slot-1 only
        tbl[13] = '{2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 5};
        tbl[14] = '{2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0};

        clear_inputs();
        issue_ready = 1'b1;
        reset = 1'b1;
        cycle();
        cycle();
        chk("rst_count", 64'(count), 0);
        chk("rst_full", 64'(full), 0);
        chk("rst_issue_valid", 64'(issue_valid), 0);
        chk("rst_issue_data", {issue_rs1, issue_rs2, issue_rd, issue_al_addr, issue_cp_addr}, 0);
        chk("rst_issue_payload", issue_payload, 0);
        reset = 1'b0;

        // Directed table
        for (int r = 0; r < 15; r++) begin
            clear_inputs();
            if (tbl[r].iv[0]) set_slot(0, tbl[r].u1[0], tbl[r].t0, 0, 0, 0, 0, tbl[r].al0);
            if (tbl[r].iv[1]) set_slot(1, tbl[r].u1[1], 0, 0, 0, 0, 0, tbl[r].al1);
            if (tbl[r].wbv) wb0(tbl[r].wbt);
            cycle();
            chk($sformatf("tbl%0d_count", r), 64'(count), 64'(tbl[r].e_cnt));
            chk($sformatf("tbl%0d_issue_valid", r), 64'(issue_valid), 64'(tbl[r].e_iv));
            if (tbl[r].e_iv) chk($sformatf("tbl%0d_al", r), 64'(issue_al_addr), 64'(tbl[r].e_al));
        end

        // Fill to 7 with not-ready entries, then check full gates inputs
        for (int k = 0; k < 6; k += 2) begin
            clear_inputs();
            set_slot(0, 1, 6'(32 + k), 0, 0, 0, 0, 5'(8 + k));
            set_slot(1, 1, 6'(33 + k), 0, 0, 0, 0, 5'(9 + k));
            cycle();
        end
        clear_inputs();
        set_slot(0, 1, 6'd38, 0, 0, 0, 0, 5'd14);
        cycle();
        chk("fill_count7", 64'(count), 7);
        chk("fill_full", 64'(full), 1);
        clear_inputs();
        set_slot(0, 0, 0, 0, 0, 0, 0, 5'd30);
        set_slot(1, 0, 0, 0, 0, 0, 0, 5'd31);
        cycle();
        chk("full_ignores_in", 64'(count), 7);
        clear_inputs();
        wb0(6'd35);
        cycle();
        chk("wake_count", 64'(count), 7);
        clear_inputs();
        cycle();
        chk("drain_count6", 64'(count), 6);
        chk("drain_full", 64'(full), 0);
        chk("drain_al", 64'(issue_al_addr), 11);
        flush = 1'b1;
        cycle();
        chk("flush1_count", 64'(count), 0);

        // Output hold under consumer stall
        clear_inputs();
        issue_ready = 1'b0;
        set_slot(0, 0, 0, 0, 0, 0, 0, 5'd20);
        set_slot(1, 0, 0, 0, 0, 0, 0, 5'd21);
        cycle();
        clear_inputs();
        set_slot(0, 1, 6'd3, 1, 0, 0, 0, 5'd22);
        cycle();
        clear_inputs();
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("hold_valid", 64'(issue_valid), 1);
            chk("hold_al", 64'(issue_al_addr), 20);
            chk("hold_count", 64'(count), 2);
        end
        issue_ready = 1'b1;
        cycle();
        chk("release_al", 64'(issue_al_addr), 21);
        chk("release_count", 64'(count), 1);

        // Flush with pending inputs and a held output
        issue_ready = 1'b0;
        set_slot(0, 1, 6'd40, 0, 0, 0, 0, 5'd24);
        set_slot(1, 1, 6'd41, 0, 0, 0, 0, 5'd25);
        cycle();
        clear_inputs();
        set_slot(0, 1, 6'd42, 0, 0, 0, 0, 5'd26);
        set_slot(1, 1, 6'd43, 0, 0, 0, 0, 5'd27);
        cycle();
        chk("preflush_count", 64'(count), 5);
        chk("preflush_valid", 64'(issue_valid), 1);
        clear_inputs();
        set_slot(0, 0, 0, 0, 0, 0, 0, 5'd28);
        set_slot(1, 0, 0, 0, 0, 0, 0, 5'd29);
        wb0(6'd40);
        flush = 1'b1;
        issue_ready = 1'b1;
        cycle();
        chk("flush_count", 64'(count), 0);
        chk("flush_valid", 64'(issue_valid), 0);
        chk("flush_full", 64'(full), 0);
        clear_inputs();
        cycle();
        chk("postflush_valid", 64'(issue_valid), 0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            clear_inputs();
            for (int s = 0; s < 2; s++) begin
                if ($urandom_range(0, 2) != 0)
                    set_slot(s, 1'($urandom), 6'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0),
                             1'($urandom), 6'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0),
                             5'($urandom));
            end
            for (int k = 0; k < NUM_WB; k++) begin
                wb_valid[k] = ($urandom_range(0, 3) == 0);
                wb_tag[k*PR_W +: PR_W] = 6'($urandom_range(0, 7));
            end
            issue_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 63) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Collapsing, age-ordered integer issue queue sitting directly downstream of the rename stage.
- Accepts up to 2 renamed instructions per cycle and tracks source-operand readiness through writeback tag broadcasts.
- Each cycle, selects the oldest instruction with both sources ready and presents it through a registered valid/ready output to the execute stage.
- Asserts a stall back to rename when it cannot guarantee space for a full 2-wide group.

Parameters:
- DEPTH, 8, number of queue entries (>=4).
- PR_W, 6, physical register tag width (clog2 NUM_PR).
- AL_W, 5, active-list index width (clog2 AL_SIZE).
- CP_W, 2, checkpoint id width.
- PAYLOAD_W, 64, opaque decoded payload (imm, alu op, branch op, etc.), carried unchanged.
- NUM_WB, 4, number of writeback tag broadcast ports.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  mispredict recall; discard all queued and output-register contents.
- in_valid  in  2  per-slot valid from rename; slot 0 is older than slot 1.
- in_uses_rs1, in_uses_rs2  in  2 each  per-slot source used.
- in_rs1, in_rs2  in  2*PR_W each  per-slot physical source tags.
- in_rs1_ready, in_rs2_ready  in  2 each  per-slot ready bits from the rename BBT lookup.
- in_rd  in  2*PR_W  per-slot destination tag.
- in_al_addr  in  2*AL_W  per-slot active-list index.
- in_cp_addr  in  2*CP_W  per-slot checkpoint id.
- in_payload  in  2*PAYLOAD_W  per-slot payload.
- full  out  1  stall to rename.
- wb_valid  in  NUM_WB  per-port broadcast valid (wb valid && uses_rd).
- wb_tag  in  NUM_WB*PR_W  per-port broadcast physical rd.
- issue_valid  out  1  output register holds an instruction.
- issue_ready  in  1  consumer accepts this cycle.
- issue_rs1, issue_rs2, issue_rd  out  PR_W each  issued tags.
- issue_al_addr  out  AL_W  issued active-list index.
- issue_cp_addr  out  CP_W  issued checkpoint id.
- issue_payload  out  PAYLOAD_W  issued payload.
- count  out  clog2(DEPTH)+1  occupied entries (excludes the output register).

Behaviour:
- Reset: all entry valids = 0; count = 0; full = 0; issue_valid = 0; all issue_* data outputs = 0.
- full = (count > DEPTH-2), computed from registered count only. While full=1, in_valid is ignored and rename is required to hold its inputs.
- Entry ready: rsN_rdy = ~uses_rsN || captured ready bit.
- Wakeup: any wb_valid[k] with wb_tag[k] == an entry's rsN sets that ready bit at the next edge.
- Incoming-instruction bypass: on insert, also compare the incoming tags against the same-cycle wb broadcast and OR the result into the stored ready bit.
- Select: the lowest-index valid entry with both sources ready, using registered ready bits only. Wakeup-to-issue-eligibility is therefore 1 cycle.
- Output register loads when (~issue_valid || issue_ready) and a selected entry exists.
  - The selected entry is removed in the same edge.
  - If the register is free but nothing is ready, issue_valid drops to 0.
  - Entry ready -> issue_valid minimum latency is 1 cycle.
- Output hold: while issue_valid && ~issue_ready, all issue_* outputs hold stable and nothing is removed.
- Per-edge update order:
  1. Remove the selected entry.
  2. Collapse so entries stay contiguous from index 0 in age order.
  3. Append accepted inputs: slot 0, then slot 1.
  4. Apply wakeup to surviving entries.
- count_next = count - removed + accepted.
- A slot-1-only input is legal; it occupies the next free index.
- flush (priority over everything except reset):
  - At the next edge, all entries are invalid, count = 0, issue_valid = 0.
  - Inputs and wb broadcasts in the flush cycle are dropped.
  - issue_ready in the flush cycle has no effect.
- Tag 0 has no special meaning; comparisons are pure equality on PR_W bits.
- Entries never wrap: the collapsing structure has no head/tail pointers.

Test Plan:
- Reset, then insert 2 with all sources ready, issue_ready=1 -> issue_valid on cycles 2 and 3; al_addr order 0 then 1; count returns to 0.
- Insert older instr A (rs1=7, not ready) and younger B (ready) -> B issues first. Drive wb_tag=7 -> A issues exactly 2 cycles after the wb cycle.
- Insert with rs1=9 not ready in the same cycle wb_tag=9 -> bypass captures it; the instruction issues the next cycle.
- Fill to count=7 with not-ready entries -> full=1; in_valid ignored; count stays 7. Wake one entry, issue it -> full drops when count=6.
- Hold issue_ready=0 for 3 cycles with issue_valid=1 -> issue_* outputs stable and count unchanged; set issue_ready=1 -> the next oldest ready entry loads.
- Queue count=5 with issue_valid=1, assert flush together with in_valid=2'b11 -> next cycle count=0, issue_valid=0, full=0.
